divmult_ctrl: RTL and testbench
===============================

# divmult_ctrl

Iterative sequencer for the CPU's MULT/DIV resource. It accepts a one-cycle start request from `control_unit`, then runs a 32-step signed multiply (radix-2 Booth) or signed divide (restoring, on magnitudes). It writes the 64-bit result into its Hi/Lo output registers, which feed `regHI`/`regLO`. It also raises the divide-by-zero exception the control unit uses for exception sequencing.

## Interface
Parameters:
- `WIDTH`, 32, operand width; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `op`  in  1  0 = MULT, 1 = DIV; sampled with `start`.
- `a`  in  WIDTH  multiplicand / dividend (from regA); latched on accepted start.
- `b`  in  WIDTH  multiplier / divisor (from regB); latched on accepted start.
- `busy`  out  1  high from the cycle after an accepted start until the cycle `done` is high (exclusive).
- `done`  out  1  one-cycle completion pulse.
- `zero_exception`  out  1  one-cycle pulse, coincident with `done`, on DIV with `b == 0`.
- `hi`  out  WIDTH  MULT: product[63:32]; DIV: remainder.
- `lo`  out  WIDTH  MULT: product[31:0]; DIV: quotient.

## Operation
- States: IDLE, MULT_RUN, DIV_RUN, DIV_FIX, FINISH.
- IDLE:
  - `start` with `op=0`: latch `a`/`b`, clear the 64-bit accumulator and counter, go to MULT_RUN.
  - `start` with `op=1` and `b != 0`: latch `|a|`, `|b|` and the two sign bits, go to DIV_RUN.
  - `start` with `op=1` and `b == 0`: go to FINISH with the zero flag set, and `hi`/`lo` unchanged.
- MULT_RUN: 32 Booth steps, one per cycle, using the Q0/Q-1 pair and an arithmetic right shift of {acc, Q, Q-1}. After step 32, load `hi`/`lo` and go to FINISH.
- DIV_RUN: 32 restoring steps, one per cycle. Each step shifts {rem, quot} left, subtracts the divisor, restores if negative, and sets the quotient bit otherwise. After step 32, go to DIV_FIX.
- DIV_FIX:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend is negative; the remainder sign follows the dividend.
  - Load `hi`/`lo` and go to FINISH.
- FINISH: assert `done` (and `zero_exception` if flagged) for exactly one cycle, then go to IDLE.
- Arithmetic:
  - All operations are two's-complement, WIDTH bits, and silently wrap.
  - `0x80000000 / -1` gives `lo=0x80000000`, `hi=0`, with no exception.
  - `|0x80000000|` is handled as unsigned 2^31.
- `start` while not IDLE is ignored, and no request is queued.
- `a`/`b` changes after acceptance do not affect the result.
- `hi`/`lo` hold their value except at the single completion load.

## Timing
- Call the cycle in which `start` is sampled in IDLE cycle 0.
- MULT: `busy` is high cycles 1–32; `hi`/`lo` are valid and `done=1` in cycle 33.
- DIV (b≠0): `busy` is high cycles 1–33; `hi`/`lo` are valid and `done=1` in cycle 34.
- DIV (b=0): `done=1` and `zero_exception=1` in cycle 1; `busy` is never asserted.
- A new `start` is accepted in the cycle after `done`, at the earliest.
- Reset values: state IDLE; `busy`, `done`, `zero_exception` = 0; `hi`, `lo` = 0; counter and accumulators = 0.
- Reset mid-operation:
  - Takes effect immediately and asynchronously to all outputs.
  - Aborts the operation with no `done` pulse.
  - The block is ready in the first cycle after reset deasserts.

## Test plan
- MULT `a=7`, `b=0xFFFFFFFD` (−3) -> `hi=0xFFFFFFFF`, `lo=0xFFFFFFEB`, `done` in cycle 33, `busy` high cycles 1–32.
- MULT `a=b=0x80000000` -> `hi=0x40000000`, `lo=0x00000000`. Then MULT `0xFFFFFFFF × 0xFFFFFFFF` -> `hi=0`, `lo=1`.
- DIV `a=0xFFFFFFF9` (−7), `b=2` -> `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`, `done` in cycle 34. Then DIV `7 / −2` -> `lo=0xFFFFFFFD`, `hi=1`.
- Preload `hi=0x11`, `lo=0x22` via a prior MULT, then DIV `5 / 0` -> `done` and `zero_exception` both high in cycle 1 only; `hi=0x11`, `lo=0x22` unchanged; `busy` stays 0.
- DIV `0x80000000 / 0xFFFFFFFF` -> `lo=0x80000000`, `hi=0`, `zero_exception=0`.
- Start MULT, pulse `start` with `op=1` in cycle 5 (must be ignored), assert `reset` low in cycle 10:
  - `busy=0`, `hi=lo=0` immediately, and no `done` pulse.
  - Then start MULT `3 × 4` -> `lo=12`, `hi=0` at cycle 33 relative to the new start.

Source files
------------

// File: rtl/divmult_ctrl.sv
// Iterative MULT/DIV sequencer: radix-2 Booth signed multiply and restoring signed divide.
// The 64-bit result lands in hi/lo once per operation; DIV by zero raises a one-cycle exception.
module divmult_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             zero_exception,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        MULT_RUN,
        DIV_RUN,
        DIV_FIX,
        FINISH
    } state_e;

    state_e           state_q, state_d;
    // acc carries one guard bit so Booth add/sub of -2^(WIDTH-1) cannot overflow;
    // during DIV it holds the running remainder, and q holds the quotient.
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             qm1_q, qm1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_neg_q, a_neg_d;
    logic             sgn_diff_q, sgn_diff_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   booth;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             last_step;

    assign last_step = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        state_d    = state_q;
        acc_d      = acc_q;
        q_d        = q_q;
        m_d        = m_q;
        qm1_d      = qm1_q;
        cnt_d      = cnt_q;
        a_neg_d    = a_neg_q;
        sgn_diff_d = sgn_diff_q;
        zero_d     = zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        booth      = acc_q;
        rem_shift  = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        rem_diff   = rem_shift - {1'b0, m_q};

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d  = '0;
                    zero_d = 1'b0;
                    acc_d  = '0;
                    qm1_d  = 1'b0;
                    if (!op) begin
                        q_d     = b;
                        m_d     = a;
                        state_d = MULT_RUN;
                    end else if (b == '0) begin
                        zero_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        // Magnitude of 0x80000000 stays 0x80000000, read as unsigned 2^31.
                        q_d        = a[WIDTH-1] ? -a : a;
                        m_d        = b[WIDTH-1] ? -b : b;
                        a_neg_d    = a[WIDTH-1];
                        sgn_diff_d = a[WIDTH-1] ^ b[WIDTH-1];
                        state_d    = DIV_RUN;
                    end
                end
            end
            MULT_RUN: begin
                unique case ({q_q[0], qm1_q})
                    2'b01:   booth = acc_q + {m_q[WIDTH-1], m_q};
                    2'b10:   booth = acc_q - {m_q[WIDTH-1], m_q};
                    default: booth = acc_q;
                endcase
                {acc_d, q_d, qm1_d} = {booth[WIDTH], booth, q_q};
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    hi_d    = acc_d[WIDTH-1:0];
                    lo_d    = q_d;
                    state_d = FINISH;
                end
            end
            DIV_RUN: begin
                // A borrow out of the guard bit means the trial subtraction went negative.
                if (rem_diff[WIDTH]) begin
                    acc_d = rem_shift;
                    q_d   = {q_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = rem_diff;
                    q_d   = {q_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + CW'(1);
                if (last_step) state_d = DIV_FIX;
            end
            DIV_FIX: begin
                lo_d    = sgn_diff_q ? -q_q : q_q;
                hi_d    = a_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                state_d = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            q_q        <= '0;
            m_q        <= '0;
            qm1_q      <= 1'b0;
            cnt_q      <= '0;
            a_neg_q    <= 1'b0;
            sgn_diff_q <= 1'b0;
            zero_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            acc_q      <= acc_d;
            q_q        <= q_d;
            m_q        <= m_d;
            qm1_q      <= qm1_d;
            cnt_q      <= cnt_d;
            a_neg_q    <= a_neg_d;
            sgn_diff_q <= sgn_diff_d;
            zero_q     <= zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy           = (state_q == MULT_RUN) || (state_q == DIV_RUN) || (state_q == DIV_FIX);
    assign done           = (state_q == FINISH);
    assign zero_exception = (state_q == FINISH) && zero_q;
    assign hi             = hi_q;
    assign lo             = lo_q;

endmodule

// File: tb/tb_divmult_ctrl.sv
// Directed bench for divmult_ctrl: expected results queued at start, compared when done pulses.
module tb_divmult_ctrl;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        zero_exception;
    logic [31:0] hi;
    logic [31:0] lo;

    exp_t        sb[$];
    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    divmult_ctrl #(.WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .op             (op),
        .a              (a),
        .b              (b),
        .busy           (busy),
        .done           (done),
        .zero_exception (zero_exception),
        .hi             (hi),
        .lo             (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start one operation in cycle 0, then follow it cycle by cycle until done.
    task automatic run_op(input logic op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                          input logic [31:0] eh, input logic [31:0] el, input logic ez,
                          input int lat);
        exp_t e;
        int   n;
        logic seen;
        sb.push_back('{hi: eh, lo: el, z: ez});
        @(negedge clk);
        start = 1'b1; op = op_v; a = a_v; b = b_v;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        n = 1;
        seen = 1'b0;
        while (!seen && n <= 40) begin
            if (done) begin
                seen = 1'b1;
                e = sb.pop_front();
                chk("done_cycle", 64'(n), 64'(lat));
                chk("busy_at_done", 64'(busy), 64'(0));
                chk("hi", 64'(hi), 64'(e.hi));
                chk("lo", 64'(lo), 64'(e.lo));
                chk("zero_exc", 64'(zero_exception), 64'(e.z));
                last_hi = e.hi;
                last_lo = e.lo;
            end else begin
                chk("busy_run", 64'(busy), 64'(n < lat));
                chk("hi_hold", 64'(hi), 64'(last_hi));
                chk("lo_hold", 64'(lo), 64'(last_lo));
                @(negedge clk);
                n++;
            end
        end
        chk("done_seen", 64'(seen), 64'(1));
        if (!seen) void'(sb.pop_front());
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("zexc_one_cycle", 64'(zero_exception), 64'(0));
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_zexc", 64'(zero_exception), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_op(1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33);
        run_op(1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33);
        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33);
        run_op(1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
        run_op(1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34);
        run_op(1'b1, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 34);
        run_op(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0, 34);
        // 0x66 * 0x2AAAAAAB = 0x11_00000022, preloading hi/lo for the divide-by-zero case.
        run_op(1'b0, 32'h00000066, 32'h2AAAAAAB, 32'h00000011, 32'h00000022, 1'b0, 33);
        run_op(1'b1, 32'd5,        32'd0,        32'h00000011, 32'h00000022, 1'b1, 1);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34);

        // Abort a MULT with reset; a stray DIV start in cycle 5 must be ignored.
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n < 10; n++) begin
            chk("abort_busy", 64'(busy), 64'(1));
            chk("abort_no_done", 64'(done), 64'(0));
            if (n == 5) begin
                start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        chk("async_busy", 64'(busy), 64'(0));
        chk("async_done", 64'(done), 64'(0));
        chk("async_hi", 64'(hi), 64'(0));
        chk("async_lo", 64'(lo), 64'(0));
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("rst_hold_done", 64'(done), 64'(0));
            chk("rst_hold_busy", 64'(busy), 64'(0));
        end
        reset = 1'b1;
        last_hi = '0;
        last_lo = '0;
        run_op(1'b0, 32'd3, 32'd4, 32'h00000000, 32'h0000000C, 1'b0, 33);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
